// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 binary32 divider.
//   Restoring shift-subtract, one quotient bit per clock (25 steps), then one
//   normalise/pack cycle. Special operands bypass the loop and finish in one cycle.
//   Denormal inputs are treated as zero, and rounding is toward zero.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         operand handshake (in_ready = idle)
//   a, b                        dividend, divisor (binary32)
//   out_valid / out_ready       result handshake
//   result                      quotient (binary32)
//   flag_invalid, flag_dz,      exception flags, held with result
//   flag_ovf, flag_unf
//
// state  | meaning
// IDLE   | waiting for an operand pair
// DIV    | one restoring-division step per cycle, cnt 24 down to 0
// NORM   | normalise quotient, range-check exponent, register result
// DONE   | result presented until out_ready
module fp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_dz,
    output logic        flag_ovf,
    output logic        flag_unf
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_result;
    logic [3:0]         r_flags;       // {invalid, dz, ovf, unf}
    logic [24:0]        r_q;
    logic [25:0]        r_rem;
    logic [23:0]        r_mb;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_exp_d;
    logic               r_sign;

    // Operand classification
    logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic w_sign, w_accept;

    assign w_a_zero = (a[30:23] == 8'h00);
    assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    assign w_b_zero = (b[30:23] == 8'h00);
    assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    assign w_sign   = a[31] ^ b[31];
    assign w_accept = in_valid && (r_state == S_IDLE);

    logic        w_special;
    logic [31:0] w_spec_res;
    logic [3:0]  w_spec_flags;

    // Order matters: invalid cases first, then inf dividend (inf/0 is a plain
    // signed inf, not divide-by-zero), then x/0, then results that are zero.
    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = 32'h0;
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res   = 32'h7FC0_0000;
            w_spec_flags = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_res   = {w_sign, 8'hFF, 23'h0};
        end else if (w_b_zero) begin
            w_spec_res   = {w_sign, 8'hFF, 23'h0};
            w_spec_flags = 4'b0100;
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res   = {w_sign, 31'h0};
        end else begin
            w_special    = 1'b0;
        end
    end

    // Division step. When rem >= mb the remainder is below 2*mb < 2^25, so the
    // top remainder bit never matters for the difference.
    logic        w_ge;
    logic [24:0] w_diff;

    assign w_ge   = (r_rem >= {2'b00, r_mb});
    assign w_diff = r_rem[24:0] - {1'b0, r_mb};

    // Normalisation: q lies in [2^23, 2^25), so at most a one-bit adjust.
    logic signed [9:0] w_e;
    logic [22:0]       w_mant;
    logic [31:0]       w_norm_res;
    logic [3:0]        w_norm_flags;

    assign w_e    = r_q[24] ? (r_exp_d + 10'sd127) : (r_exp_d + 10'sd126);
    assign w_mant = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_comb begin
        w_norm_res   = {r_sign, w_e[7:0], w_mant};
        w_norm_flags = 4'b0000;
        if (w_e >= 10'sd255) begin
            w_norm_res   = {r_sign, 8'hFF, 23'h0};
            w_norm_flags = 4'b0010;
        end else if (w_e <= 10'sd0) begin
            w_norm_res   = {r_sign, 31'h0};
            w_norm_flags = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_DIV;
            S_DIV:  if (r_cnt == 5'd0) w_next = S_NORM;
            S_NORM: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 32'h0;
            r_flags  <= 4'b0000;
            r_q      <= 25'h0;
            r_rem    <= 26'h0;
            r_mb     <= 24'h0;
            r_cnt    <= 5'd0;
            r_exp_d  <= 10'sd0;
            r_sign   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_flags <= w_special ? w_spec_flags : 4'b0000;
                    if (w_special) r_result <= w_spec_res;
                    r_sign  <= w_sign;
                    r_mb    <= {1'b1, b[22:0]};
                    r_rem   <= {2'b01, a[22:0]};
                    r_q     <= 25'h0;
                    r_cnt   <= 5'd24;
                    r_exp_d <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]});
                end
                S_DIV: begin
                    // Shifting q left fills bit cnt on each of the 25 steps.
                    r_q   <= {r_q[23:0], w_ge};
                    r_rem <= w_ge ? {w_diff, 1'b0} : {r_rem[24:0], 1'b0};
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                S_NORM: begin
                    r_result <= w_norm_res;
                    r_flags  <= w_norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign flag_invalid = r_flags[3];
    assign flag_dz      = r_flags[2];
    assign flag_ovf     = r_flags[1];
    assign flag_unf     = r_flags[0];

endmodule
